spram8_resp: RTL
================

Name: spram8_resp

Overview:
- Responder (slave) end of the 8-bit memory bus (we/ai/vi/vo): a byte-addressed 128 KB memory built from four 16K×16 SPRAM banks.
- Maps byte accesses onto 16-bit banks using nibble write masks.
- Gives a registered read with 1-cycle latency and forwards a just-written byte.
- Contains a zero-fill sequencer that clears all memory after reset or on request, reporting busy; eForth core and loaders sit on the initiator side.

Parameters:
- DSZ, 8, data bus width (fixed; fixed-width datapath)
- ASZ, 17, byte address width (20 - clog2(DSZ))
- CLR_ON_RST, 1, 1 = start zero-fill automatically when reset releases
- CLR_WORDS, 16384, words per bank swept by zero-fill (reduce in simulation only)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable from initiator, qualified by ai/vi same cycle
- ai  input  17  byte address: [16:15] bank, [14:1] word, [0] byte lane
- vi  input  8  write data
- vo  output  8  read data, valid 1 cycle after ai presented
- clr  input  1  single-cycle pulse requests zero-fill (honoured only in IDLE)
- busy  output  1  high while zero-fill in progress; bus ignored

Behaviour:
- Reset (rst_n low, async):
  - vo=0; busy=0.
  - State = INIT; clear counter = 0; forward flag = 0.
  - SPRAM contents not guaranteed.
- FSM states: INIT, CLEAR, IDLE.
  - INIT: one cycle after rst_n release; goes to CLEAR if CLR_ON_RST=1, else IDLE.
  - CLEAR: busy=1.
    - Each cycle writes 16'h0000 with mask 4'b1111 to word cnt of all four banks simultaneously.
    - cnt increments by one per cycle.
    - After cnt=CLR_WORDS-1 is written, go to IDLE; busy drops the following cycle.
    - Full clear = CLR_WORDS cycles.
  - IDLE: busy=0; serve the bus. clr=1 → CLEAR with cnt=0 on the next edge.
    - A bus access in the same cycle as clr is still served.
- Write (IDLE, we=1):
  - Bank ai[16:15], word ai[14:1], data {vi,vi}.
  - Mask 4'b0011 if ai[0]=0, 4'b1100 if ai[0]=1.
  - Other banks not enabled.
- Read (IDLE, we=0):
  - All banks addressed with ai[14:1].
  - Bank select and lane are registered.
  - Next cycle: vo = selected bank dout[7:0] (lane 0) or dout[15:8] (lane 1).
  - Latency exactly 1 cycle; back-to-back reads give one result per cycle.
- Write forwarding: the cycle after a write, vo = the byte just written. SPRAM output during a write cycle is undefined and never used.
- vo holds its last value in any cycle with no new read result, i.e. the cycle after a CLEAR step or INIT.
- During CLEAR: we/ai/vi ignored, no memory effect; vo=0.
- Address wrap: none; all 2^17 addresses are valid and distinct.
- Reset mid-CLEAR: abort; re-enter INIT and restart the sweep from cnt=0 per CLR_ON_RST.
- clr while busy: ignored (no restart, no queueing).

Test Plan:
- Power-up clear (CLR_WORDS=16): release rst_n → busy rises after INIT, stays high 16 cycles; read 0x00000, 0x1FFFF, 0x0A5A5 → each returns 0x00 one cycle later.
- Byte lanes: write 0x12 @0x00100, then 0x34 @0x00101 → reading 0x00100 gives 0x12 and 0x00101 gives 0x34; bank word holds 16'h3412; neighbouring 0x00102 still 0x00.
- Bank decode: write 0xA1 @0x00010, 0xB2 @0x08010, 0xC3 @0x10010, 0xD4 @0x18010 → each reads back its own value, no aliasing.
- Forwarding and throughput: write 0x5A @0x00200, then read 0x00201 on the next cycle → vo shows 0x5A in the cycle after the write, then 0x00. Reads of 0x00100/0x00101/0x00100 on consecutive cycles → 0x12/0x34/0x12 on consecutive cycles.
- clr pulse in IDLE: populated memory → busy high for CLR_WORDS cycles, writes issued meanwhile have no effect, all previously written bytes read 0x00 afterwards.
- Reset mid-clear: assert rst_n low at cnt=7 → vo=0 and busy=0 immediately. On release, the sweep restarts from 0 and takes the full CLR_WORDS cycles.

Source files
------------

// File: rtl/spram8_resp.sv
// Byte-wide responder on four 16K x 16 single-port RAM banks (128 KB),
// with 1-cycle registered reads, write forwarding and a zero-fill sequencer.

module spram16k (
    input  logic        clk,
    input  logic [13:0] addr,
    input  logic [15:0] din,
    input  logic [3:0]  mask,
    input  logic        wren,
    output logic [15:0] dout
);
    logic [15:0] mem [0:16383];

    // NOTE: the storage array has no reset; clearing is the sequencer's job.
    always_ff @(posedge clk) begin
        if (wren) begin
            for (int n = 0; n < 4; n++) begin
                if (mask[n]) mem[addr][n*4 +: 4] <= din[n*4 +: 4];
            end
        end else begin
            dout <= mem[addr];
        end
    end
endmodule

module spram8_resp #(
    parameter int DSZ        = 8,
    parameter int ASZ        = 17,
    parameter bit CLR_ON_RST = 1'b1,
    parameter int CLR_WORDS  = 16384
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [ASZ-1:0] ai,
    input  logic [DSZ-1:0] vi,
    output logic [DSZ-1:0] vo,
    input  logic           clr,
    output logic           busy
);
    typedef enum logic [1:0] {INIT, CLEAR, IDLE} state_t;

    localparam logic [13:0] CNT_LAST = 14'(CLR_WORDS - 1);

    state_t         state;
    logic [13:0]    cnt;
    logic           rd_valid;
    logic           rd_lane;
    logic [1:0]     rd_bank;
    logic           fwd;
    logic [DSZ-1:0] fwd_data;
    logic [DSZ-1:0] hold;

    logic [13:0]    bank_addr;
    logic [15:0]    bank_din;
    logic [3:0]     bank_mask;
    logic [3:0]     bank_wren;
    logic [15:0]    bank_dout [4];
    logic [15:0]    rd_word;

    wire clearing = (state == CLEAR);
    wire serving  = (state == IDLE);

    // Clearing writes all banks at once; otherwise only the addressed bank is written.
    always_comb begin
        bank_addr = clearing ? cnt : ai[14:1];
        bank_din  = clearing ? 16'h0000 : {vi, vi};
        bank_mask = clearing ? 4'b1111 : (ai[0] ? 4'b1100 : 4'b0011);
        bank_wren = '0;
        for (int b = 0; b < 4; b++) begin
            bank_wren[b] = clearing || (serving && we && (ai[16:15] == 2'(b)));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        spram16k u_bank (
            .clk  (clk),
            .addr (bank_addr),
            .din  (bank_din),
            .mask (bank_mask),
            .wren (bank_wren[g]),
            .dout (bank_dout[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_lane  <= 1'b0;
            rd_bank  <= '0;
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rd_valid <= serving && !we;
            fwd      <= serving && we;
            rd_lane  <= ai[0];
            rd_bank  <= ai[16:15];
            fwd_data <= vi;
            case (state)
                INIT: begin
                    cnt   <= '0;
                    state <= CLR_ON_RST ? CLEAR : IDLE;
                    busy  <= CLR_ON_RST;
                end
                CLEAR: begin
                    cnt <= cnt + 14'd1;
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_word = bank_dout[rd_bank];

    // With no fresh read or forwarded byte, vo repeats whatever it showed last cycle.
    always_comb begin
        vo = hold;
        if (busy)          vo = '0;
        else if (rd_valid) vo = rd_lane ? rd_word[15:8] : rd_word[7:0];
        else if (fwd)      vo = fwd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold <= '0;
        else        hold <= vo;
    end
endmodule
